nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Multi-cycle wide adder. It accepts two WIDTH-bit operands through a valid/ready handshake and adds them one nibble per clock, least-significant nibble first. Each nibble goes through one instance of the team's 4-bit structural ripple adder, and that adder's carry_out is registered and fed back into its carry_in on the next cycle. The block sits directly in front of the 4-bit adder slice: it sequences operands into the slice and assembles the slice's sum and carry results into a wide result.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, number of nibble steps (derived; not overridable).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and carry_in are valid.
in_ready  output  1  block can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
carry_in  input  1  carry into nibble 0.
out_valid  output  1  sum/carry_out are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered result.
carry_out  output  1  carry out of the most significant nibble.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=IDLE.
  - Clears sum, carry_out, out_valid, the nibble index, the carry register and the operand registers.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
- Clock/reset: one clock domain; reset is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&in_ready: capture a, b and carry_in into internal registers, set idx=0, go to RUN.
- RUN:
  - in_ready=0.
  - The adder slice sees a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg.
  - Each clock: sum[4*idx+:4] <= slice sum; carry_reg <= slice carry_out; idx <= idx+1.
  - When idx==NIB-1: carry_out <= slice carry_out, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1; sum and carry_out are held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_valid is ignored in DONE.
- Latency: out_valid rises exactly NIB clocks after the acceptance edge (4 for WIDTH=16).
- Throughput: at most one operation per NIB+2 clocks.
- Nibble ordering: sum nibbles are written LSB first. Upper sum bits hold stale values until DONE; consumers may only sample sum while out_valid=1.
- Operand stability: changes on a, b or carry_in after the acceptance edge have no effect on the result.
- Arithmetic: {carry_out,sum} = a + b + carry_in, computed unsigned and exact over WIDTH+1 bits; no wrap loss.
- in_valid while busy: ignored; no queuing.
- out_ready outside DONE: ignored.
- Reset mid-RUN or in DONE: the operation is discarded, all outputs return to reset values immediately, and no partial result is ever flagged valid.
- idx width: clog2(NIB). It never exceeds NIB-1 and is reset to 0 on every acceptance.

Test Plan:
1. WIDTH=16; a=0x1234, b=0x1111, cin=0, out_ready=1 -> out_valid on the 4th clock after acceptance, sum=0x2345, carry_out=0, then in_ready=1 the cycle after the DONE handshake.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1; the carry propagates through all 4 nibble steps. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, carry_out=1.
3. Backpressure: a=0x00F0, b=0x0010, out_ready=0 for 6 clocks after out_valid -> sum=0x0100 and out_valid stay stable, in_ready=0 throughout. Pulsing in_valid with new operands during this window has no effect. Raising out_ready completes the transfer once.
4. Operand stability: after acceptance of a=0x8000, b=0x8000, cin=0, change a/b every cycle -> result still sum=0x0000, carry_out=1.
5. Reset mid-RUN: assert rst_n low 2 clocks after acceptance -> out_valid, sum and carry_out go to 0 immediately. After release, a new op a=0x0003, b=0x0004 -> sum=0x0007, carry_out=0.
6. Back-to-back ops: in_valid held high with out_ready=1 -> successive acceptances exactly NIB+2 clocks apart, each result correct, over ≥50 random operand pairs checked against a+b+cin.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle wide adder that pushes one nibble per clock,
// LSB first, through a single 4-bit ripple slice with a registered carry loop.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic [4:0] c;
  assign c[0] = carry_in;
  assign carry_out = c[4];
  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx;
  logic             carry_reg, armed, accept, last;
  logic [3:0]       a_nib, b_nib, slice_sum;
  logic             slice_co;

  // armed keeps in_ready low until the first clock after reset release
  assign in_ready = armed && state == IDLE;
  assign busy     = state != IDLE;
  assign accept   = in_valid && in_ready;
  assign last     = idx == IW'(NIB - 1);
  assign a_nib    = a_reg[4*idx +: 4];
  assign b_nib    = b_reg[4*idx +: 4];

  ripple_adder4 u_slice (
    .a(a_nib), .b(b_nib), .carry_in(carry_reg),
    .sum(slice_sum), .carry_out(slice_co)
  );

  always_comb begin
    state_nx = state == IDLE ? (accept ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= carry_in;
        idx       <= '0;
      end else if (state == RUN) begin
        sum[4*idx +: 4] <= slice_sum;
        carry_reg       <= slice_co;
        idx             <= last ? '0 : idx + 1'b1;
        if (last) begin
          carry_out <= slice_co;
          out_valid <= 1'b1;
        end
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the serial adder
// against plain (WIDTH+1)-bit arithmetic.
module tb_nibble_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, carry_in = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, carry_out, busy;
  logic [W-1:0] sum;
  int           total = 0, bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return 32'(x) + 32'(y) + 32'(c);
  endfunction

  // Issues one op and returns with the result visible; hold keeps out_ready low.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input bit scr, input bit hold);
    logic [31:0] exp;
    int n;
    exp = model(x, y, c);
    out_ready = !hold;
    a = x; b = y; carry_in = c; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready before op", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (scr) begin a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom); end
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), NIB);
    chk("result", 32'({carry_out, sum}), exp);
    if (!hold) begin
      @(negedge clk);
      chk("out_valid dropped", 32'(out_valid), 0);
      chk("in_ready after done", 32'(in_ready), 1);
    end
  endtask

  logic [31:0] q[$];
  int acc, got, cyc, last_acc;

  initial begin
    #12;
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst sum", 32'(sum), 0);
    chk("rst carry_out", 32'(carry_out), 0);
    chk("rst busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("in_ready after release", 32'(in_ready), 1);

    do_op(16'h1234, 16'h1111, 0, 0, 0);
    do_op(16'hFFFF, 16'h0001, 0, 0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1, 0, 0);
    do_op(16'h8000, 16'h8000, 0, 1, 0);

    // backpressure with in_valid pulses that must be ignored
    do_op(16'h00F0, 16'h0010, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 1);
      chk("bp sum", 32'({carry_out, sum}), 32'h0100);
      chk("bp in_ready", 32'(in_ready), 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp release out_valid", 32'(out_valid), 0);
    chk("bp release in_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("bp single transfer", 32'(out_valid), 0);

    // reset two clocks into RUN
    a = 16'h5678; b = 16'h9ABC; carry_in = 1; in_valid = 1;
    @(negedge clk); in_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("busy before reset", 32'(busy), 1);
    rst_n = 0; #1;
    chk("midrun rst out_valid", 32'(out_valid), 0);
    chk("midrun rst sum", 32'(sum), 0);
    chk("midrun rst carry_out", 32'(carry_out), 0);
    chk("midrun rst in_ready", 32'(in_ready), 0);
    chk("midrun rst busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no partial valid", 32'(out_valid), 0);
    end
    do_op(16'h0003, 16'h0004, 0, 0, 0);

    // back-to-back random ops with in_valid held high
    out_ready = 1; in_valid = 1; acc = 0; got = 0; cyc = 0; last_acc = -1;
    a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    while (got < 50 && cyc < 2000) begin
      if (in_ready && in_valid) begin
        q.push_back(model(a, b, carry_in));
        if (last_acc >= 0) chk("b2b spacing", 32'(cyc - last_acc), NIB + 2);
        last_acc = cyc;
        acc++;
      end
      if (out_valid)
        begin
          chk("b2b result", 32'({carry_out, sum}), q.size() > 0 ? q.pop_front() : 32'hFFFF_FFFF);
          got++;
        end
      @(negedge clk);
      cyc++;
      if (acc == 50) in_valid = 0;
      a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    end
    chk("b2b count", 32'(got), 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
